// File: rtl/data_convert_button.sv
// Expands a 2-bit button code into a one-hot pulse held for HOLD_CYCLES,
// followed by GAP_CYCLES all-low cycles, with a one-entry request queue.
module data_convert_button #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] dataIn,
    input  logic       dataValid,
    output logic [3:0] buttonOut,
    output logic       busy,
    output logic       pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] code, code_n;
    logic       q_full, q_full_n;
    logic [1:0] q_code, q_code_n;
    logic       ovf_n;
    logic       decide;
    logic [3:0] button_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        code_n   = code;
        q_full_n = q_full;
        q_code_n = q_code;
        ovf_n    = 1'b0;
        decide   = 1'b0;

        case (state)
            IDLE: begin
                if (dataValid) begin
                    code_n  = dataIn;
                    cnt_n   = HOLD_LOAD;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    if (HAS_GAP) begin
                        cnt_n   = GAP_LOAD;
                        state_n = GAP;
                    end else begin
                        decide = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    decide = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A queued code outranks a fresh request; the fresh one then refills the slot.
        if (decide) begin
            if (q_full) begin
                code_n   = q_code;
                cnt_n    = HOLD_LOAD;
                state_n  = HOLD;
                q_full_n = dataValid;
                if (dataValid) begin
                    q_code_n = dataIn;
                end
            end else if (dataValid) begin
                code_n  = dataIn;
                cnt_n   = HOLD_LOAD;
                state_n = HOLD;
            end else begin
                state_n = IDLE;
            end
        end else if ((state != IDLE) && dataValid) begin
            if (!q_full) begin
                q_full_n = 1'b1;
                q_code_n = dataIn;
            end else begin
                ovf_n = 1'b1;
            end
        end

        button_n = (state_n == HOLD) ? (4'b0001 << code_n) : 4'b0000;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            q_full    <= 1'b0;
            buttonOut <= 4'b0000;
            busy      <= 1'b0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q_full    <= q_full_n;
            buttonOut <= button_n;
            busy      <= (state_n != IDLE);
            pending   <= q_full_n;
            overflow  <= ovf_n;
        end
    end

    // Codes only matter while state/q_full qualify them, so they need no reset.
    always_ff @(posedge clock) begin
        code   <= code_n;
        q_code <= q_code_n;
    end

endmodule

// File: tb/tb_data_convert_button.sv
// Bench for data_convert_button: directed vector tables, GAP_CYCLES=0 streaming,
// mid-pulse reset, and random traffic against a timestamp-based reference model.
module tb_data_convert_button;

    localparam int H0 = 4, G0 = 1, H1 = 4, G1 = 0;
    localparam int B0 = 1, B1 = 2, B2 = 4, B3 = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dataIn = 2'd0;
    logic       dataValid = 1'b0;
    logic [3:0] button0, button1;
    logic       busy0, busy1, pend0, pend1, ovf0, ovf1;

    always #5 clock = ~clock;

    data_convert_button #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
        .buttonOut(button0), .busy(busy0), .pending(pend0), .overflow(ovf0)
    );

    data_convert_button #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut0 (
        .clock(clock), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
        .buttonOut(button1), .busy(busy1), .pending(pend1), .overflow(ovf1)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: a pulse is described by its code and first high cycle;
    // its period ends HOLD+GAP cycles later, where the next request is chosen.
    int m_h[2] = '{H0, H1};
    int m_g[2] = '{G0, G1};
    bit m_act[2];
    int m_s[2];
    int m_c[2];
    bit m_qf[2];
    int m_qc[2];
    bit m_ovf[2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 1'b0;
            m_qf[m]  = 1'b0;
            m_ovf[m] = 1'b0;
        end
    endfunction

    function automatic void model_edge(int m, bit v, int d, int e);
        m_ovf[m] = 1'b0;
        if (!m_act[m]) begin
            if (v) begin
                m_act[m] = 1'b1;
                m_s[m]   = e + 1;
                m_c[m]   = d;
            end
        end else if (e == m_s[m] + m_h[m] + m_g[m] - 1) begin
            if (m_qf[m]) begin
                m_c[m]  = m_qc[m];
                m_s[m]  = e + 1;
                m_qf[m] = v;
                if (v) m_qc[m] = d;
            end else if (v) begin
                m_c[m] = d;
                m_s[m] = e + 1;
            end else begin
                m_act[m] = 1'b0;
            end
        end else if (v) begin
            if (!m_qf[m]) begin
                m_qf[m] = 1'b1;
                m_qc[m] = d;
            end else begin
                m_ovf[m] = 1'b1;
            end
        end
    endfunction

    function automatic int model_btn(int m, int t);
        if (m_act[m] && (t < m_s[m] + m_h[m])) return 1 << m_c[m];
        return 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic compare_models();
        check("m0 button", int'(button0), model_btn(0, edge_n));
        check("m0 busy", int'(busy0), int'(m_act[0]));
        check("m0 pending", int'(pend0), int'(m_qf[0]));
        check("m0 overflow", int'(ovf0), int'(m_ovf[0]));
        check("m1 button", int'(button1), model_btn(1, edge_n));
        check("m1 busy", int'(busy1), int'(m_act[1]));
        check("m1 pending", int'(pend1), int'(m_qf[1]));
        check("m1 overflow", int'(ovf1), int'(m_ovf[1]));
        check("onehot0", int'($countones(button0) <= 1), 1);
        check("onehot1", int'($countones(button1) <= 1), 1);
    endtask

    task automatic step(input bit v, input logic [1:0] d);
        dataValid = v;
        dataIn    = d;
        @(posedge clock);
        #1;
        model_edge(0, v, int'(d), edge_n);
        model_edge(1, v, int'(d), edge_n);
        edge_n++;
        compare_models();
    endtask

    typedef struct {
        bit         v;
        logic [1:0] d;
        logic [3:0] btn;
        bit         bsy;
        bit         pnd;
        bit         ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int v, int d, int b, int bz, int p, int o);
        tbl.push_back('{(v != 0), 2'(d), 4'(b), (bz != 0), (p != 0), (o != 0)});
    endfunction

    int seq[5] = '{0, 0, 1, 2, 3};

    initial begin
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset button", int'(button0), 0);
        check("reset busy", int'(busy0), 0);
        check("reset pending", int'(pend0), 0);
        check("reset overflow", int'(ovf0), 0);
        check("reset button g0", int'(button1), 0);
        reset = 1'b1;

        // Single request
        add(1, 2, B2, 1, 0, 0);
        repeat (3) add(0, 0, B2, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Queued request
        add(1, 2, B2, 1, 0, 0);
        add(0, 0, B2, 1, 0, 0);
        add(1, 1, B2, 1, 1, 0);
        add(0, 0, B2, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        repeat (4) add(0, 0, B1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Overflow
        add(1, 0, B0, 1, 0, 0);
        add(1, 3, B0, 1, 1, 0);
        add(1, 1, B0, 1, 1, 1);
        add(0, 0, B0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        repeat (4) add(0, 0, B3, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Refill at the consume edge
        add(1, 0, B0, 1, 0, 0);
        add(1, 3, B0, 1, 1, 0);
        repeat (2) add(0, 0, B0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        add(1, 2, B3, 1, 1, 0);
        repeat (3) add(0, 0, B3, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        repeat (4) add(0, 0, B2, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d button", i), int'(button0), int'(tbl[i].btn));
            check($sformatf("tbl%0d busy", i), int'(busy0), int'(tbl[i].bsy));
            check($sformatf("tbl%0d pending", i), int'(pend0), int'(tbl[i].pnd));
            check($sformatf("tbl%0d overflow", i), int'(ovf0), int'(tbl[i].ovf));
        end

        // GAP_CYCLES=0 streaming: pulses 0,0,1,2,3 back to back
        for (int i = 0; i < 20; i++) begin
            step(i < 16, 2'(i / 4));
            check($sformatf("stream%0d button", i), int'(button1), 1 << seq[i / 4]);
        end
        step(1'b0, 2'd0);
        check("stream end button", int'(button1), 0);
        check("stream end busy", int'(busy1), 0);
        repeat (10) step(1'b0, 2'd0);

        // Mid-pulse reset with a full queue
        step(1'b1, 2'd0);
        step(1'b1, 2'd3);
        check("pre-reset pending", int'(pend0), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midreset button", int'(button0), 0);
        check("midreset pending", int'(pend0), 0);
        check("midreset busy", int'(busy0), 0);
        check("midreset overflow", int'(ovf0), 0);
        check("midreset button g0", int'(button1), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0);
            check($sformatf("postreset%0d button", i), int'(button0), 0);
        end

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
